// File: rtl/add_pkg.sv
// Shared constants and types for the pipelined adder add_pipe_n.
package add_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  function automatic int calc_stages(input int width, input int seg);
    return width / seg;
  endfunction

  // Control part of a stage record; data fields are sized by the top's parameters.
  typedef struct packed {
    logic vld;
    logic cy;
    logic ovf;
  } stage_ctl_t;

endpackage

// File: rtl/add_seg.sv
// add_seg: combinational SEG-bit ripple-carry adder, one per pipeline stage.
module add_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic c;

  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/add_pipe_n.sv
// add_pipe_n: pipelined WIDTH-bit adder, one SEG-bit ripple segment per stage, valid/ready on both sides.
// Defining ADD_PIPE_OVF_EN adds the registered signed-overflow output ovf.
module add_pipe_n
  import add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] add_0,
  input  logic [WIDTH-1:0] add_1,
  input  logic             c_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
`ifdef ADD_PIPE_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  logic   adv;

  // Whole pipe moves in lockstep; bubbles are not collapsed.
  assign adv      = ~stage_q[STAGES-1].ctl.vld | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t         prev;
    stage_t         nxt;
    logic [SEG-1:0] s;
    logic           co;

    if (k == 0) begin : g_head
      always_comb begin
        prev         = '0;
        prev.ctl.vld = in_valid;
        prev.ctl.cy  = c_in;
        prev.a       = add_0;
        prev.b       = add_1;
      end
    end else begin : g_body
      assign prev = stage_q[k-1];
    end

    add_seg #(.SEG(SEG)) u_seg (
      .a  (prev.a[k*SEG +: SEG]),
      .b  (prev.b[k*SEG +: SEG]),
      .ci (prev.ctl.cy),
      .s  (s),
      .co (co)
    );

    // Carry into the segment MSB is recovered as s ^ a ^ b at that bit.
    always_comb begin
      nxt                   = prev;
      nxt.sum[k*SEG +: SEG] = s;
      nxt.ctl.cy            = co;
      nxt.ctl.ovf           = co ^ s[SEG-1] ^ prev.a[k*SEG+SEG-1] ^ prev.b[k*SEG+SEG-1];
    end

    assign stage_d[k] = nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign out       = stage_q[STAGES-1].sum;
  assign c_out     = stage_q[STAGES-1].ctl.cy;
  assign out_valid = stage_q[STAGES-1].ctl.vld;
`ifdef ADD_PIPE_OVF_EN
  assign ovf       = stage_q[STAGES-1].ctl.ovf;
`endif

endmodule

// File: doc/add_pipe_n.md
Name: add_pipe_n

Overview:
- Parametrised, pipelined successor to the 4-bit combinational adder.
- Adds two WIDTH-bit operands plus carry-in, WIDTH/SEG ripple segments, one segment per pipeline stage.
- Carry is registered between stages; one new operation accepted per cycle.
- Valid/ready handshake on input and output with backpressure; used as the arithmetic core for later ALU/accumulator experiments.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG.
- SEG, 4, bits added per pipeline stage. STAGES = WIDTH/SEG is a derived localparam and equals the latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- add_0  input  WIDTH  operand A.
- add_1  input  WIDTH  operand B.
- c_in  input  1  carry-in.
- in_valid  input  1  operands/c_in valid this cycle.
- in_ready  output  1  block can accept; transfer when in_valid & in_ready.
- out  output  WIDTH  registered sum.
- c_out  output  1  registered carry-out of MSB.
- out_valid  output  1  out/c_out hold a result.
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.

Behaviour:
- Reset: when rst=1 at a clock edge, clear all stage valid bits, out=0, c_out=0, out_valid=0. Reset mid-operation discards every in-flight result. in_ready is combinational, so it is 1 during and immediately after reset.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv. When adv=0, every stage register holds its value, including valid bits, operands, partial sums and carries.
- Stage k (0..STAGES-1), on adv:
  - adds bits [k*SEG +: SEG] of the delayed operands plus the carry from stage k-1 (stage 0 uses c_in);
  - registers the SEG-bit partial sum alongside the already-computed lower sum bits, the still-unused upper operand bits, and the carry out;
  - sets its valid bit from the previous stage's valid bit (stage 0 takes in_valid).
- Output: the last stage's registers drive out, c_out and out_valid directly. Latency is exactly STAGES cycles from accept to out_valid when no stall occurs. Throughput is 1 per cycle.
- Bubbles are not collapsed: an empty stage still waits on adv.
- Arithmetic: {c_out, out} = add_0 + add_1 + c_in, unsigned, modulo 2^(WIDTH+1); no saturation. Wrap example: FFFF+0001+0 -> out=0000, c_out=1.
- Stall: out_valid=1 and out_ready=0 freezes the whole pipe. The held out value stays stable, and in_valid is ignored because in_ready=0.
- Simultaneous events: a new input and an output consumed in the same cycle both transfer; no loss, no duplication.
- Invalid slots: operand registers of invalid slots may hold don't-care data; out is only meaningful while out_valid=1.
- Degenerate case: SEG=WIDTH gives STAGES=1, i.e. a registered single-stage adder.

Optional Feature:
- Macro ADD_PIPE_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow of add_0+add_1+c_in: carry into MSB XOR carry out of MSB.
  - ovf is registered with the final stage, reset to 0, and qualified by out_valid like out.
- Undefined: the port and its logic are absent. The remaining behaviour is identical.

Decomposition:
- Shared package add_pkg:
  - default WIDTH/SEG constants;
  - a function computing STAGES;
  - a typedef for the per-stage record (valid, partial sum, remaining operands, carry).
- One natural sub-module: add_seg, a combinational SEG-bit ripple adder (a, b, ci -> s, co), instantiated once per stage via generate.
- Top module holds the stage registers and the handshake.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then release with in_valid=0 -> out_valid=0, out=0000, c_out=0, in_ready=1.
- Single op (WIDTH=16, SEG=4): 1234+4321, c_in=1 accepted at cycle t -> out_valid rises at t+4 with out=5556, c_out=0.
- Carry ripple/wrap: FFFF+0001, c_in=0 -> out=0000, c_out=1. 7FFF+0001 with ADD_PIPE_OVF_EN defined -> out=8000, ovf=1.
- Back-to-back plus stall: 8 random ops on consecutive cycles with out_ready=0 for cycles 5-7.
  - All 8 results arrive in order and match the reference sum.
  - in_ready=0 while stalled; out is unchanged during the stall.
- Reset mid-flight: accept 3 ops, assert rst on the next edge -> out_valid=0 next cycle and no stale result ever appears.
- Parameter sweep: WIDTH=8/SEG=8 (latency 1) and WIDTH=32/SEG=4 (latency 8) with 1000 random ops each -> zero mismatches against the reference sum.
